// File: rtl/player_ctl_pkg.sv
// Shared constants, state encoding and clamp helper for the player motion controller
// and the downstream sprite-draw stage.
package player_ctl_pkg;

   localparam int SCREEN_W    = 1024;
   localparam int SCREEN_H    = 768;
   localparam int SPRITE_W    = 48;
   localparam int SPRITE_H    = 64;
   localparam int LAND_FRAMES = 8;

   localparam logic [11:0]        X_START     = 12'd488;
   localparam logic signed [13:0] WALK_SPEED  = 14'sd2;
   localparam logic signed [7:0]  AIR_SPEED   = 8'sd4;
   localparam logic [4:0]         MIN_CHARGE  = 5'd4;
   localparam logic [4:0]         MAX_CHARGE  = 5'd24;
   localparam logic signed [7:0]  MAX_FALL    = 8'sd16;

   localparam logic signed [13:0] FLOOR_Y_S = 14'(SCREEN_H - SPRITE_H);
   localparam logic signed [13:0] X_MAX_S   = 14'(SCREEN_W - SPRITE_W);
   localparam logic [11:0]        FLOOR_Y   = 12'(SCREEN_H - SPRITE_H);
   localparam logic [11:0]        X_MAX     = 12'(SCREEN_W - SPRITE_W);
   localparam logic [2:0]         LAND_LAST = 3'(LAND_FRAMES - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CHARGE = 2'd1,
      ST_AIR    = 2'd2,
      ST_LAND   = 2'd3
   } player_state_t;

   function automatic logic [11:0] clamp_x(input logic signed [13:0] v);
      if (v < 14'sd0) begin
         return 12'd0;
      end else if (v > X_MAX_S) begin
         return X_MAX;
      end else begin
         return v[11:0];
      end
   endfunction

endpackage

// File: rtl/player_ctl_if.sv
// Frame/button inputs and sprite-origin outputs of the player controller.
// master: the controller; slave: the timing/button source and sprite-draw consumer.
interface player_ctl_if;
   logic        vblnk;
   logic        btn_left;
   logic        btn_right;
   logic        btn_jump;
   logic [11:0] x_value;
   logic [11:0] y_value;
   logic [1:0]  sprite_sel;
   logic        facing;
   logic [4:0]  charge_level;

   modport master (
      input  vblnk, btn_left, btn_right, btn_jump,
      output x_value, y_value, sprite_sel, facing, charge_level
   );

   modport slave (
      output vblnk, btn_left, btn_right, btn_jump,
      input  x_value, y_value, sprite_sel, facing, charge_level
   );
endinterface

// File: rtl/player_ctl_frame_tick_gen.sv
// vblnk rising-edge detector: one-cycle tick at the start of each vertical blank.
module frame_tick_gen (
   input  logic clk,
   input  logic rst,
   input  logic vblnk,
   output logic tick
);

   logic vblnk_q_r;

   // delayed copy of vblnk for edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         vblnk_q_r <= 1'b0;
      end else begin
         vblnk_q_r <= vblnk;
      end
   end

   assign tick = vblnk & ~vblnk_q_r;

endmodule

// File: rtl/player_ctl.sv
// Jump-King style player motion controller, updated once per frame on vblnk rising edge.
// Optional PLAYER_CTL_AUTOJUMP_EN: auto-launch when charge is full with jump still held.
module player_ctl
   import player_ctl_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   player_ctl_if.master    bus
);

   logic                tick_s;
   player_state_t       state_r, state_nxt_s;
   logic [11:0]         x_r, y_r, x_nxt_s, y_nxt_s;
   logic signed [7:0]   vx_r, vy_r, vx_nxt_s, vy_nxt_s, vy_inc_s;
   logic [4:0]          charge_r, charge_nxt_s;
   logic                facing_r, facing_nxt_s;
   logic [2:0]          land_cnt_r, land_cnt_nxt_s;
   logic signed [13:0]  x_pos_s, x_air_s, y_air_s;
   logic                left_only_s, right_only_s;
   logic                jump_ok_s, launch_s;

   frame_tick_gen u_tick (
      .clk   (clk),
      .rst   (rst),
      .vblnk (bus.vblnk),
      .tick  (tick_s)
   );

   assign left_only_s  = bus.btn_left & ~bus.btn_right;
   assign right_only_s = bus.btn_right & ~bus.btn_left;
   assign x_pos_s      = $signed({2'b00, x_r});
   assign x_air_s      = x_pos_s + {{6{vx_r[7]}}, vx_r};
   assign y_air_s      = $signed({2'b00, y_r}) + {{6{vy_r[7]}}, vy_r};
   assign vy_inc_s     = (vy_r >= MAX_FALL) ? MAX_FALL : vy_r + 8'sd1;

`ifdef PLAYER_CTL_AUTOJUMP_EN
   logic armed_r, armed_nxt_s;

   assign jump_ok_s = bus.btn_jump & armed_r;
   assign launch_s  = ~bus.btn_jump | (charge_r == MAX_CHARGE);

   // re-arm on release in IDLE, disarm when launching with jump still held
   always_comb begin
      armed_nxt_s = armed_r;
      if ((state_r == ST_IDLE) && !bus.btn_jump) begin
         armed_nxt_s = 1'b1;
      end else if ((state_r == ST_CHARGE) && launch_s && bus.btn_jump) begin
         armed_nxt_s = 1'b0;
      end else begin
         armed_nxt_s = armed_r;
      end
   end

   // jump re-arm flag register
   always_ff @(posedge clk) begin
      if (rst) begin
         armed_r <= 1'b1;
      end else if (tick_s) begin
         armed_r <= armed_nxt_s;
      end
   end
`else
   assign jump_ok_s = bus.btn_jump;
   assign launch_s  = ~bus.btn_jump;
`endif

   // FSM state register, advanced once per frame
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else if (tick_s) begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (jump_ok_s) begin
               state_nxt_s = ST_CHARGE;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_CHARGE: begin
            if (launch_s) begin
               state_nxt_s = ST_AIR;
            end else begin
               state_nxt_s = ST_CHARGE;
            end
         end
         ST_AIR: begin
            if (y_air_s >= FLOOR_Y_S) begin
               state_nxt_s = ST_LAND;
            end else begin
               state_nxt_s = ST_AIR;
            end
         end
         ST_LAND: begin
            if (land_cnt_r == 3'd0) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_LAND;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // FSM output/datapath logic: next position, velocity, charge and facing
   always_comb begin
      x_nxt_s        = x_r;
      y_nxt_s        = y_r;
      vx_nxt_s       = vx_r;
      vy_nxt_s       = vy_r;
      charge_nxt_s   = charge_r;
      facing_nxt_s   = facing_r;
      land_cnt_nxt_s = land_cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (jump_ok_s) begin
               charge_nxt_s = MIN_CHARGE;
            end else if (left_only_s) begin
               x_nxt_s      = clamp_x(x_pos_s - WALK_SPEED);
               facing_nxt_s = 1'b1;
            end else if (right_only_s) begin
               x_nxt_s      = clamp_x(x_pos_s + WALK_SPEED);
               facing_nxt_s = 1'b0;
            end else begin
               x_nxt_s = x_r;
            end
         end
         ST_CHARGE: begin
            if (launch_s) begin
               vy_nxt_s     = 8'sd0 - $signed({3'b000, charge_r});
               charge_nxt_s = 5'd0;
               if (left_only_s) begin
                  vx_nxt_s     = 8'sd0 - AIR_SPEED;
                  facing_nxt_s = 1'b1;
               end else if (right_only_s) begin
                  vx_nxt_s     = AIR_SPEED;
                  facing_nxt_s = 1'b0;
               end else begin
                  vx_nxt_s = 8'sd0;
               end
            end else if (charge_r < MAX_CHARGE) begin
               charge_nxt_s = charge_r + 5'd1;
            end else begin
               charge_nxt_s = MAX_CHARGE;
            end
         end
         ST_AIR: begin
            vy_nxt_s = vy_inc_s;
            if (x_air_s < 14'sd0) begin
               x_nxt_s      = 12'd0;
               vx_nxt_s     = 8'sd0 - vx_r;
               facing_nxt_s = ~facing_r;
            end else if (x_air_s > X_MAX_S) begin
               x_nxt_s      = X_MAX;
               vx_nxt_s     = 8'sd0 - vx_r;
               facing_nxt_s = ~facing_r;
            end else begin
               x_nxt_s = x_air_s[11:0];
            end
            // floor wins over the bounce's vx reversal but keeps the facing toggle
            if (y_air_s >= FLOOR_Y_S) begin
               y_nxt_s        = FLOOR_Y;
               vx_nxt_s       = 8'sd0;
               vy_nxt_s       = 8'sd0;
               land_cnt_nxt_s = LAND_LAST;
            end else if (y_air_s < 14'sd0) begin
               y_nxt_s  = 12'd0;
               vy_nxt_s = 8'sd0;
            end else begin
               y_nxt_s = y_air_s[11:0];
            end
         end
         ST_LAND: begin
            if (land_cnt_r != 3'd0) begin
               land_cnt_nxt_s = land_cnt_r - 3'd1;
            end else begin
               land_cnt_nxt_s = 3'd0;
            end
         end
         default: begin
            charge_nxt_s = 5'd0;
         end
      endcase
   end

   // position, velocity and charge registers, advanced once per frame
   always_ff @(posedge clk) begin
      if (rst) begin
         x_r        <= X_START;
         y_r        <= FLOOR_Y;
         vx_r       <= 8'sd0;
         vy_r       <= 8'sd0;
         charge_r   <= 5'd0;
         facing_r   <= 1'b0;
         land_cnt_r <= 3'd0;
      end else if (tick_s) begin
         x_r        <= x_nxt_s;
         y_r        <= y_nxt_s;
         vx_r       <= vx_nxt_s;
         vy_r       <= vy_nxt_s;
         charge_r   <= charge_nxt_s;
         facing_r   <= facing_nxt_s;
         land_cnt_r <= land_cnt_nxt_s;
      end
   end

   assign bus.x_value      = x_r;
   assign bus.y_value      = y_r;
   assign bus.sprite_sel   = state_r;
   assign bus.facing       = facing_r;
   assign bus.charge_level = charge_r;

endmodule

// File: doc/player_ctl.md
Name: player_ctl

Overview:
- Player motion controller. Sits directly upstream of the sprite-draw stage and drives its x_value/y_value sprite-origin inputs.
- Implements Jump King style movement:
  - walk on ground;
  - hold jump to charge, release to launch;
  - ballistic flight under gravity, with wall bounce and a landing freeze.
- Position updates once per frame, at the rising edge of vblnk, so the sprite never tears mid-frame.

Parameters:
- SCREEN_W, 1024, visible width in px
- SCREEN_H, 768, visible height in px
- SPRITE_W, 48, sprite width in px
- SPRITE_H, 64, sprite height in px
- X_START, 488, reset x position
- WALK_SPEED, 2, ground px/frame
- AIR_SPEED, 4, horizontal airborne px/frame
- MIN_CHARGE, 4, initial charge on press
- MAX_CHARGE, 24, charge ceiling
- MAX_FALL, 16, terminal downward velocity in px/frame
- LAND_FRAMES, 8, frozen frames after landing

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- vblnk  in  1  vertical blank from the VGA timing bus
- btn_left  in  1  synchronized, debounced level
- btn_right  in  1  synchronized, debounced level
- btn_jump  in  1  synchronized, debounced level
- x_value  out  12  sprite left edge
- y_value  out  12  sprite top edge
- sprite_sel  out  2  0 = idle, 1 = charge, 2 = air, 3 = land
- facing  out  1  0 = right, 1 = left
- charge_level  out  5  current charge; 0 outside CHARGE

Behaviour:
- Derived constants:
  - FLOOR_Y = SCREEN_H - SPRITE_H (704)
  - X_MAX = SCREEN_W - SPRITE_W (976)
- Frame tick:
  - vblnk_q is registered; tick = vblnk & ~vblnk_q.
  - All state, position and velocity registers update only on clock edges where tick = 1.
  - Outputs are registered, so a tick in cycle N is visible in cycle N+1.
  - Buttons are sampled only in tick cycles.
- Reset values:
  - x = X_START, y = FLOOR_Y
  - vx = 0, vy = 0, charge = 0
  - state IDLE, facing = 0, sprite_sel = 0
  - vblnk_q = 0
- Velocities: vx, vy are signed 8-bit. Position math is signed 14-bit, then clamped.
- IDLE (on floor):
  - jump=1: go to CHARGE, charge = MIN_CHARGE, no x motion this tick.
  - Otherwise, exactly one of left/right held: x ± WALK_SPEED, clamped to [0, X_MAX]; facing updated.
  - Both or neither held: no motion, facing unchanged.
- CHARGE:
  - No walking.
  - jump held: charge = min(charge+1, MAX_CHARGE).
  - jump released:
    - vy = -charge.
    - vx = +AIR_SPEED (right only), -AIR_SPEED (left only), else 0.
    - facing updated if vx ≠ 0.
    - charge = 0; go to AIR.
    - Position unchanged this tick.
- AIR:
  - Buttons ignored.
  - x' = x + vx, y' = y + vy, vy' = min(vy+1, MAX_FALL).
  - Wall: if x' < 0, x = 0 and vx = -vx. If x' > X_MAX, x = X_MAX and vx = -vx. Facing toggles on bounce.
  - Ceiling: y' < 0 gives y = 0, vy' = 0.
  - Floor: y' >= FLOOR_Y gives y = FLOOR_Y, vx = vy = 0, land counter = LAND_FRAMES-1, go to LAND.
  - Wall and floor in the same tick: both apply.
- LAND:
  - Buttons ignored; counter decrements each tick.
  - At 0, go to IDLE on that tick, so exactly LAND_FRAMES ticks are spent in LAND.
- sprite_sel equals the state encoding: IDLE 0, CHARGE 1, AIR 2, LAND 3.
- rst asserted in any state, including mid-flight, restores reset values on the next edge.
- The state register has an illegal-state default to IDLE.

Optional Feature:
- Macro: PLAYER_CTL_AUTOJUMP_EN.
- Defined: when charge == MAX_CHARGE at a CHARGE tick with jump still held, launch exactly as on release, using the direction held that tick. A new charge requires jump to be released and pressed again; track this with a jump_armed flag, cleared on auto-launch and set when jump = 0 in IDLE.
- Undefined: charge saturates at MAX_CHARGE indefinitely and launch happens only on release.

Decomposition:
- vga_pkg additions:
  - player_state_t enum (IDLE, CHARGE, AIR, LAND)
  - SPRITE_W / SPRITE_H localparams, shared with the sprite-draw stage so that its rectangle size and this block's clamps stay consistent
- One natural sub-module: frame_tick_gen (vblnk rising-edge detector, 1-cycle pulse), reusable by other per-frame logic.
- Everything else stays in player_ctl.

Test Plan:
- Reset: hold rst 3 cycles -> x = 488, y = 704, sprite_sel = 0, facing = 0, charge_level = 0. No change while vblnk stays low.
- Walk: btn_right for 10 ticks -> x = 508, facing = 0. Both buttons for 5 ticks -> x stays 508. btn_left from x = 2 for 3 ticks -> x = 0, with no wrap to 4094.
- Vertical jump: jump held 6 ticks then released, no direction:
  - charge_level = 9 at release tick, then the launch tick leaves y = 704;
  - y minimum is 704 - 45 = 659;
  - returns to 704 with sprite_sel = 3 for exactly 8 ticks, then 0.
- Wall bounce: x = 970, right+jump, release at charge = 4, right held -> x = 974 then 976 (clamped), vx becomes -4, facing = 1, next x = 972.
- Saturation: jump held 40 ticks -> charge_level sticks at 24. With PLAYER_CTL_AUTOJUMP_EN: launch occurs on the tick charge is already 24, and holding jump after landing does not re-enter CHARGE.
- Reset mid-flight: assert rst while sprite_sel = 2 and y = 680 -> next cycle x = 488, y = 704, sprite_sel = 0.
